// File: rtl/bus_mux_n.sv
// N-slave router for the picorv32 native memory port: decodes base/mask windows from the
// look-ahead address and ends unmapped or hung accesses with an error response.
module bus_mux_n #(
  parameter int                      N_SLAVES   = 2,
  parameter logic [N_SLAVES*32-1:0]  SLAVE_BASE = {32'h0100_0000, 32'h0000_0000},
  parameter logic [N_SLAVES*32-1:0]  SLAVE_MASK = {32'hffff_f000, 32'hffff_0000},
  parameter int unsigned             TIMEOUT    = 255,
  parameter logic [31:0]             ERR_RDATA  = 32'hdead_beef
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [31:0]              i_la_addr,
  input  logic                     i_la_read,
  input  logic                     i_la_write,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic [31:0]              o_rdata,
  output logic [N_SLAVES-1:0]      o_slave_valid,
  input  logic [N_SLAVES-1:0]      i_slave_ready,
  input  logic [N_SLAVES*32-1:0]   i_slave_rdata,
  output logic                     o_error,
  output logic [7:0]               o_err_count
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_ERR   = 2'd2;

  logic [1:0]          state_reg, state_next;
  logic [SW-1:0]       sel_reg, sel_next;
  logic                hit_reg, hit_next;
  logic                seen_reg, seen_next;
  logic [7:0]          wait_cnt_reg, wait_cnt_next;
  logic [7:0]          err_count_reg;

  logic [N_SLAVES-1:0] la_hit;
  logic [N_SLAVES-1:0] sel_oh;
  logic [31:0]         rdata_masked [N_SLAVES];
  logic [SW-1:0]       dec_sel;
  logic [31:0]         sel_rdata;
  logic                sel_ready;
  logic                la_strobe;
  logic                timeout_hit;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slave
      assign la_hit[gi]       = (i_la_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
      assign sel_oh[gi]       = hit_reg && (sel_reg == SW'(gi));
      assign rdata_masked[gi] = sel_oh[gi] ? i_slave_rdata[32*gi +: 32] : 32'h0;
    end
  endgenerate

  // Walk from the top index down so the lowest hitting window wins on overlap.
  always_comb begin
    dec_sel   = '0;
    sel_rdata = '0;
    for (int k = N_SLAVES - 1; k >= 0; k--) begin
      if (la_hit[k]) dec_sel = SW'(k);
    end
    for (int k = 0; k < N_SLAVES; k++) begin
      sel_rdata = sel_rdata | rdata_masked[k];
    end
  end

  assign sel_ready   = |(i_slave_ready & sel_oh);
  assign la_strobe   = i_la_read | i_la_write;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == 8'(TIMEOUT));

  always_comb begin
    o_ready       = 1'b0;
    o_error       = 1'b0;
    o_rdata       = 32'h0;
    o_slave_valid = '0;
    case (state_reg)
      ST_ARMED: begin
        o_slave_valid = i_valid ? sel_oh : '0;
        o_ready       = i_valid & sel_ready;
        o_rdata       = sel_ready ? sel_rdata : 32'h0;
      end
      ST_ERR: begin
        o_ready = i_valid;
        o_error = i_valid;
        o_rdata = ERR_RDATA;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    hit_next      = hit_reg;
    seen_next     = seen_reg;
    wait_cnt_next = wait_cnt_reg;
    // Completion and idle share one decode path, which is what allows back-to-back accesses.
    if (state_reg == ST_IDLE || o_ready) begin
      wait_cnt_next = 8'h0;
      seen_next     = 1'b0;
      if (la_strobe) begin
        state_next = ST_ARMED;
        sel_next   = dec_sel;
        hit_next   = |la_hit;
      end else begin
        state_next = ST_IDLE;
      end
    end else if (state_reg == ST_ARMED) begin
      if (i_valid) begin
        seen_next = 1'b1;
        if (!hit_reg || timeout_hit) begin
          state_next = ST_ERR;
        end else if (wait_cnt_reg != 8'hff) begin
          wait_cnt_next = wait_cnt_reg + 8'h1;
        end
      end else if (seen_reg) begin
        state_next    = ST_IDLE;
        wait_cnt_next = 8'h0;
      end
    end else begin
      state_next    = ST_IDLE;
      wait_cnt_next = 8'h0;
      seen_next     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      sel_reg       <= '0;
      hit_reg       <= 1'b0;
      seen_reg      <= 1'b0;
      wait_cnt_reg  <= 8'h0;
      err_count_reg <= 8'h0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      hit_reg      <= hit_next;
      seen_reg     <= seen_next;
      wait_cnt_reg <= wait_cnt_next;
      if (o_error && err_count_reg != 8'hff) err_count_reg <= err_count_reg + 8'h1;
    end
  end

  assign o_err_count = err_count_reg;

endmodule

// File: tb/tb_bus_mux_n.sv
// Scoreboard bench for bus_mux_n: two slaves with the default windows and a short timeout.
module tb_bus_mux_n;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] i_la_addr;
  logic        i_la_read, i_la_write, i_valid;
  logic        o_ready, o_error;
  logic [31:0] o_rdata;
  logic [1:0]  o_slave_valid, i_slave_ready;
  logic [63:0] i_slave_rdata;
  logic [7:0]  o_err_count;
  logic [31:0] s0_data, s1_data;

  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb_q[$];
  exp_t e;
  int total = 0;
  int bad = 0;
  int err_model = 0;

  always #5 clock = ~clock;
  assign i_slave_rdata = {s1_data, s0_data};

  bus_mux_n #(
    .N_SLAVES(2),
    .SLAVE_BASE({32'h0100_0000, 32'h0000_0000}),
    .SLAVE_MASK({32'hffff_f000, 32'hffff_0000}),
    .TIMEOUT(4),
    .ERR_RDATA(32'hdead_beef)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .i_la_addr(i_la_addr), .i_la_read(i_la_read), .i_la_write(i_la_write),
    .i_valid(i_valid), .o_ready(o_ready), .o_rdata(o_rdata),
    .o_slave_valid(o_slave_valid), .i_slave_ready(i_slave_ready), .i_slave_rdata(i_slave_rdata),
    .o_error(o_error), .o_err_count(o_err_count)
  );

  // Look-ahead cycle, then valid held until o_ready (bounded); ready_at<0 means never ready.
  task automatic drive_access(input logic [31:0] addr, input logic wr, input int ready_at,
                              input logic [1:0] rdy_mask, output int sv_cycles, output logic [1:0] sv_seen,
                              output int ready_cycle, output logic [31:0] obs_rdata, output logic obs_err,
                              output logic [7:0] obs_cnt);
    @(posedge clock); #1;
    i_la_addr = addr; i_la_read = !wr; i_la_write = wr; i_valid = 1'b0; i_slave_ready = 2'b00;
    @(posedge clock); #1;
    i_la_read = 1'b0; i_la_write = 1'b0; i_valid = 1'b1;
    sv_cycles = 0; sv_seen = 2'b00; ready_cycle = -1; obs_rdata = 32'h0; obs_err = 1'b0;
    for (int n = 0; n < 40; n++) begin
      i_slave_ready = (n == ready_at) ? rdy_mask : 2'b00;
      @(negedge clock);
      if (o_slave_valid != 2'b00) begin sv_cycles++; sv_seen = sv_seen | o_slave_valid; end
      if (o_ready) begin ready_cycle = n; obs_rdata = o_rdata; obs_err = o_error; break; end
      @(posedge clock); #1;
    end
    @(posedge clock); #1;
    i_valid = 1'b0; i_slave_ready = 2'b00;
    obs_cnt = o_err_count;
    $display("txn addr=%h wr=%0b sv=%b sv_cycles=%0d ready_cycle=%0d rdata=%h err=%0b err_count=%0d",
             addr, wr, sv_seen, sv_cycles, ready_cycle, obs_rdata, obs_err, obs_cnt);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; i_la_addr = 32'h0; i_la_read = 1'b0; i_la_write = 1'b0; i_valid = 1'b0;
    i_slave_ready = 2'b00; s0_data = 32'h0; s1_data = 32'h0;
    repeat (5) begin
      @(negedge clock);
      total++; if (o_ready !== 1'b0 || o_error !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b/%b want=0/0", o_ready, o_error); end
      total++; if (o_slave_valid !== 2'b00) begin bad++; $display("FAIL reset_sv got=%b want=00", o_slave_valid); end
      total++; if (o_err_count !== 8'd0 || o_rdata !== 32'h0) begin bad++; $display("FAIL reset_cnt_rdata got=%0d/%h want=0/0", o_err_count, o_rdata); end
    end
    @(posedge clock); #1 reset_n = 1'b1; i_valid = 1'b1;
    @(negedge clock);
    total++; if (o_ready !== 1'b0 || o_slave_valid !== 2'b00) begin bad++; $display("FAIL idle_after_reset got=%b/%b want=0/00", o_ready, o_slave_valid); end
    @(posedge clock); #1 i_valid = 1'b0;
    $display("txn reset released err_count=%0d", o_err_count);
  endtask

  task automatic test_read_same_cycle();
    int c, rc; logic [1:0] s; logic [31:0] rd; logic er; logic [7:0] cnt;
    s0_data = 32'h1234_5678;
    sb_q.push_back('{32'h1234_5678, 1'b0});
    drive_access(32'h0000_0100, 1'b0, 0, 2'b01, c, s, rc, rd, er, cnt);
    e = sb_q.pop_front();
    total++; if (s !== 2'b01 || c !== 1) begin bad++; $display("FAIL rd0_sv got=%b x%0d want=01 x1", s, c); end
    total++; if (rc !== 0) begin bad++; $display("FAIL rd0_ready_cycle got=%0d want=0", rc); end
    total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL rd0_data got=%h/%b want=%h/%b", rd, er, e.rdata, e.err); end
  endtask

  task automatic test_write_delayed();
    int c, rc; logic [1:0] s; logic [31:0] rd; logic er; logic [7:0] cnt;
    s1_data = 32'hcafe_0001;
    sb_q.push_back('{32'hcafe_0001, 1'b0});
    drive_access(32'h0100_0004, 1'b1, 3, 2'b10, c, s, rc, rd, er, cnt);
    e = sb_q.pop_front();
    total++; if (s !== 2'b10 || c !== 4) begin bad++; $display("FAIL wr1_sv got=%b x%0d want=10 x4", s, c); end
    total++; if (rc !== 3) begin bad++; $display("FAIL wr1_ready_cycle got=%0d want=3", rc); end
    total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL wr1_data got=%h/%b want=%h/%b", rd, er, e.rdata, e.err); end
    total++; if (cnt !== 8'(err_model)) begin bad++; $display("FAIL wr1_err_count got=%0d want=%0d", cnt, err_model); end
  endtask

  task automatic test_unmapped();
    int c, rc; logic [1:0] s; logic [31:0] rd; logic er; logic [7:0] cnt;
    sb_q.push_back('{32'hdead_beef, 1'b1});
    drive_access(32'h0200_0000, 1'b0, 0, 2'b11, c, s, rc, rd, er, cnt);
    e = sb_q.pop_front();
    err_model = 1;
    total++; if (c !== 0) begin bad++; $display("FAIL miss_sv got=%0d cycles want=0", c); end
    total++; if (rc !== 1) begin bad++; $display("FAIL miss_ready_cycle got=%0d want=1", rc); end
    total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL miss_data got=%h/%b want=%h/%b", rd, er, e.rdata, e.err); end
    total++; if (cnt !== 8'(err_model)) begin bad++; $display("FAIL miss_err_count got=%0d want=%0d", cnt, err_model); end
  endtask

  task automatic test_window_edges();
    logic [31:0] addrs [4] = '{32'h0000_fffc, 32'h0100_0ffc, 32'h0100_1000, 32'h0001_0000};
    logic [1:0]  svs   [4] = '{2'b01, 2'b10, 2'b00, 2'b00};
    int c, rc; logic [1:0] s; logic [31:0] rd; logic er; logic [7:0] cnt;
    s0_data = 32'h0a0a_0000; s1_data = 32'h0b0b_0001;
    for (int i = 0; i < 4; i++) begin
      sb_q.push_back(svs[i] == 2'b01 ? '{32'h0a0a_0000, 1'b0} :
                     svs[i] == 2'b10 ? '{32'h0b0b_0001, 1'b0} : '{32'hdead_beef, 1'b1});
      drive_access(addrs[i], 1'b0, 1, 2'b11, c, s, rc, rd, er, cnt);
      e = sb_q.pop_front();
      if (e.err && err_model < 255) err_model++;
      total++; if (s !== svs[i]) begin bad++; $display("FAIL edge%0d_sv got=%b want=%b", i, s, svs[i]); end
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL edge%0d_data got=%h/%b want=%h/%b", i, rd, er, e.rdata, e.err); end
      total++; if (cnt !== 8'(err_model)) begin bad++; $display("FAIL edge%0d_err_count got=%0d want=%0d", i, cnt, err_model); end
    end
  endtask

  task automatic test_timeout(input int reps);
    int c, rc; logic [1:0] s; logic [31:0] rd; logic er; logic [7:0] cnt;
    for (int i = 0; i < reps; i++) begin
      sb_q.push_back('{32'hdead_beef, 1'b1});
      drive_access(32'h0000_0200, 1'b0, -1, 2'b01, c, s, rc, rd, er, cnt);
      e = sb_q.pop_front();
      if (err_model < 255) err_model++;
      total++; if (s !== 2'b01 || c !== 5) begin bad++; $display("FAIL to%0d_sv got=%b x%0d want=01 x5", i, s, c); end
      total++; if (rc !== 5) begin bad++; $display("FAIL to%0d_ready_cycle got=%0d want=5", i, rc); end
      total++; if (rd !== e.rdata || er !== e.err) begin bad++; $display("FAIL to%0d_data got=%h/%b want=%h/%b", i, rd, er, e.rdata, e.err); end
      total++; if (cnt !== 8'(err_model)) begin bad++; $display("FAIL to%0d_err_count got=%0d want=%0d", i, cnt, err_model); end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clock); #1 i_la_addr = 32'h0000_0300; i_la_read = 1'b1;
    @(posedge clock); #1 i_la_read = 1'b0; i_valid = 1'b1; i_slave_ready = 2'b00;
    @(posedge clock); #1 reset_n = 1'b0;
    @(negedge clock);
    total++; if (o_slave_valid !== 2'b01) begin bad++; $display("FAIL mid_sv_before got=%b want=01", o_slave_valid); end
    @(negedge clock);
    err_model = 0;
    total++; if (o_slave_valid !== 2'b00 || o_ready !== 1'b0) begin bad++; $display("FAIL mid_after got=%b/%b want=00/0", o_slave_valid, o_ready); end
    total++; if (o_err_count !== 8'd0) begin bad++; $display("FAIL mid_err_count got=%0d want=0", o_err_count); end
    @(posedge clock); #1 reset_n = 1'b1; i_valid = 1'b0;
    $display("txn reset mid-transaction sv=%b ready=%b", o_slave_valid, o_ready);
  endtask

  task automatic test_back_to_back();
    s0_data = 32'h5555_0000; s1_data = 32'h6666_0001;
    sb_q.push_back('{32'h5555_0000, 1'b0});
    sb_q.push_back('{32'h6666_0001, 1'b0});
    @(posedge clock); #1 i_la_addr = 32'h0000_0040; i_la_read = 1'b1;
    @(posedge clock); #1 i_valid = 1'b1; i_slave_ready = 2'b01; i_la_addr = 32'h0100_0010;
    @(negedge clock);
    e = sb_q.pop_front();
    total++; if (o_slave_valid !== 2'b01 || o_ready !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b/%b want=01/1", o_slave_valid, o_ready); end
    total++; if (o_rdata !== e.rdata || o_error !== e.err) begin bad++; $display("FAIL b2b_first_data got=%h/%b want=%h/%b", o_rdata, o_error, e.rdata, e.err); end
    $display("txn b2b slave0 sv=%b ready=%b rdata=%h", o_slave_valid, o_ready, o_rdata);
    @(posedge clock); #1 i_la_read = 1'b0; i_slave_ready = 2'b10;
    @(negedge clock);
    e = sb_q.pop_front();
    total++; if (o_slave_valid !== 2'b10 || o_ready !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b/%b want=10/1", o_slave_valid, o_ready); end
    total++; if (o_rdata !== e.rdata || o_error !== e.err) begin bad++; $display("FAIL b2b_second_data got=%h/%b want=%h/%b", o_rdata, o_error, e.rdata, e.err); end
    $display("txn b2b slave1 sv=%b ready=%b rdata=%h", o_slave_valid, o_ready, o_rdata);
    @(posedge clock); #1 i_valid = 1'b0; i_slave_ready = 2'b00;
    @(negedge clock);
    total++; if (o_ready !== 1'b0 || o_error !== 1'b0) begin bad++; $display("FAIL b2b_idle got=%b/%b want=0/0", o_ready, o_error); end
  endtask

  initial begin
    test_reset();
    test_read_same_cycle();
    test_write_delayed();
    test_unmapped();
    test_window_edges();
    test_timeout(1);
    test_back_to_back();
    test_reset_mid();
    test_timeout(300);
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL sb_leftover got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_mux_n.md
Name: bus_mux_n

Overview:
- Parametrised N-slave successor to the two-slave PicoRV32 bus multiplexer.
- Sits between the picorv32 native memory port and N slaves: TCM, io_reg, and future peripherals.
- Decodes each slave's address window from a base/mask pair, using the look-ahead address one cycle early.
- Routes valid/ready/rdata, and terminates accesses to unmapped addresses and hung slaves with an error response instead of stalling the CPU forever.

Parameters:
- N_SLAVES, 2, number of slave ports (1..16).
- SLAVE_BASE, {32'h0100_0000, 32'h0000_0000}, packed N_SLAVES*32 base addresses; slave k uses bits [32k+31:32k].
- SLAVE_MASK, {32'hffff_f000, 32'hffff_0000}, packed N_SLAVES*32 masks; slave k hits when (addr & MASK_k) == BASE_k.
- TIMEOUT, 255, maximum wait cycles for slave ready after valid; 0 disables the timeout.
- ERR_RDATA, 32'hdead_beef, read data returned on error termination.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- i_la_addr  in  32  CPU look-ahead address.
- i_la_read  in  1  CPU look-ahead read strobe.
- i_la_write  in  1  CPU look-ahead write strobe.
- i_valid  in  1  CPU mem_valid.
- o_ready  out  1  CPU mem_ready.
- o_rdata  out  32  CPU mem_rdata.
- o_slave_valid  out  N_SLAVES  per-slave valid, one-hot or zero.
- i_slave_ready  in  N_SLAVES  per-slave ready.
- i_slave_rdata  in  N_SLAVES*32  packed slave read data; slave k at [32k+31:32k].
- o_error  out  1  one-cycle pulse on each error termination.
- o_err_count  out  8  saturating count of error terminations.

Behaviour:
- Reset, sampled on clock edge while reset_n=0:
  - state=IDLE, sel=0, hit=0, wait counter=0, o_err_count=0.
  - o_ready=0, o_error=0, o_slave_valid=0, o_rdata=0.
- Decode:
  - In IDLE, when i_la_read|i_la_write, register sel = lowest index k that hits, and hit = any hit. Next state is ARMED.
  - Overlapping windows: the lowest index wins.
- ARMED, waiting for i_valid:
  - o_slave_valid[sel] = i_valid & hit, combinational.
  - o_ready = i_slave_ready[sel] & i_valid & hit.
  - o_rdata = i_slave_rdata[sel] while hit and the slave is ready, else 0.
  - Zero added latency: a slave answering ready in the same cycle as valid completes in that cycle.
- Completion: the cycle with o_ready=1 moves the state to IDLE. A new look-ahead strobe in that same cycle is decoded directly, so the next state is ARMED with the new sel. This gives back-to-back operation without bubbles.
- Miss (hit=0) with i_valid=1:
  - One wait cycle; next cycle drive o_ready=1, o_rdata=ERR_RDATA, o_error=1.
  - No o_slave_valid bit asserts.
  - Writes are dropped.
- Timeout:
  - Wait counter (8 bits) counts cycles in which i_valid=1 and ready=0.
  - When the counter reaches TIMEOUT (TIMEOUT>0), the next cycle does all of the following:
    - deasserts o_slave_valid[sel];
    - drives o_ready=1, o_rdata=ERR_RDATA, o_error=1.
  - Counter clears on any completion.
- o_err_count: increments on each o_error pulse; saturates at 255 and holds.
- i_valid dropping before completion (only possible via reset): return to IDLE and clear the counter.
- Reset mid-transaction: state, sel and counter clear immediately on the next edge; no ready is issued.
- Look-ahead strobe while ARMED and not completing: ignored; sel is held.
- o_ready and o_error are never asserted while i_valid=0.

Test Plan:
- Reset hold of 5 clocks, then IDLE: o_ready=0, o_slave_valid=0, o_err_count=0 throughout reset; state remains IDLE after release.
- Read to 32'h0000_0100, slave 0 ready in the same cycle with rdata 32'h1234_5678 -> o_slave_valid=2'b01, o_ready=1 in the valid cycle, o_rdata=32'h1234_5678.
- Write to 32'h0100_0004, slave 1 ready after 3 cycles -> o_slave_valid=2'b10 for 4 cycles, single o_ready pulse, o_error=0.
- Read to unmapped 32'h0200_0000 -> no slave valid, o_ready and o_error one cycle after valid, o_rdata=32'hdead_beef, o_err_count=1.
- Slave 0 never ready, TIMEOUT=4 -> valid held 5 cycles then dropped, o_ready=1 with rdata 32'hdead_beef, o_error=1; 300 such timeouts leave o_err_count=255.
- Back-to-back: look-ahead for slave 1 in the completion cycle of a slave-0 access -> next access routes to slave 1 with no idle cycle.
